// File: rtl/jf_pkg.sv
// Shared definitions for the jump-and-fight character logic: motion FSM states,
// screen/sprite geometry and contact-vector bit positions.
package jf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    H_CHK,
    H_WAIT,
    V_CHK,
    V_WAIT
  } motion_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_RIGHT,
    DIR_LEFT
  } h_dir_t;

  localparam int BLUE_W   = 23;
  localparam int BLUE_H   = 45;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int COL_DOWN  = 0;
  localparam int COL_UP    = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_LEFT  = 3;

  // Magnitude of a signed 5-bit velocity; -16 maps to 16.
  function automatic logic [4:0] vy_mag(input logic signed [4:0] v);
    logic [4:0] mag_s;
    if (v[4]) begin
      mag_s = 5'(-v);
    end else begin
      mag_s = 5'(v);
    end
    return mag_s;
  endfunction

endpackage

// File: rtl/blue_motion.sv
// Per-frame motion controller for the blue character: moves one pixel per step
// and waits for the registered contact vector to catch up before the next step.
module blue_motion
  import jf_pkg::*;
#(
  parameter logic [9:0] X_INIT  = 10'd40,
  parameter logic [8:0] Y_INIT  = 9'd390,
  parameter logic [9:0] X_MAX   = 10'd617,
  parameter logic [8:0] Y_MAX   = 9'd435,
  parameter int         H_SPEED = 2,
  parameter int         JUMP_V  = 8,
  parameter int         V_MAX   = 8,
  parameter int         SETTLE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic [3:0] is_collision,
  output logic [9:0] x_blue,
  output logic [8:0] y_blue,
  output logic       on_ground,
  output logic       facing_left,
  output logic       busy
);

  localparam logic [3:0]        H_STEPS     = 4'(H_SPEED);
  localparam logic signed [4:0] VY_JUMP     = 5'(-JUMP_V);
  localparam logic signed [4:0] VY_MAX      = 5'(V_MAX);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

  motion_state_t     state_r;
  h_dir_t            dir_r;
  logic [3:0]        h_cnt_r;
  logic [4:0]        v_cnt_r;
  logic [3:0]        settle_r;
  logic signed [4:0] vy_r;

  h_dir_t            dir_s;
  logic signed [4:0] vy_plan_s;
  logic              h_blocked_s;
  logic              v_blocked_s;

  // Decode keys into a direction and compute the velocity latched in PLAN.
  always_comb begin
    dir_s     = DIR_NONE;
    vy_plan_s = vy_r;
    if (key_right && !key_left) begin
      dir_s = DIR_RIGHT;
    end else if (key_left && !key_right) begin
      dir_s = DIR_LEFT;
    end else begin
      dir_s = DIR_NONE;
    end
    if (is_collision[COL_DOWN] && key_jump) begin
      vy_plan_s = VY_JUMP;
    end else if (is_collision[COL_DOWN]) begin
      vy_plan_s = 5'sd0;
    end else if (vy_r >= VY_MAX) begin
      vy_plan_s = VY_MAX;
    end else begin
      vy_plan_s = vy_r + 5'sd1;
    end
  end

  // Blocking conditions for the pending horizontal and vertical pixel step.
  always_comb begin
    h_blocked_s = 1'b1;
    v_blocked_s = 1'b1;
    case (dir_r)
      DIR_RIGHT: h_blocked_s = is_collision[COL_RIGHT] || (x_blue == X_MAX);
      DIR_LEFT:  h_blocked_s = is_collision[COL_LEFT] || (x_blue == 10'd0);
      default:   h_blocked_s = 1'b1;
    endcase
    if (vy_r[4]) begin
      v_blocked_s = is_collision[COL_UP] || (y_blue == 9'd0);
    end else begin
      v_blocked_s = is_collision[COL_DOWN] || (y_blue == Y_MAX);
    end
  end

  // Motion burst FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      dir_r       <= DIR_NONE;
      h_cnt_r     <= 4'd0;
      v_cnt_r     <= 5'd0;
      settle_r    <= 4'd0;
      vy_r        <= 5'sd0;
      x_blue      <= X_INIT;
      y_blue      <= Y_INIT;
      on_ground   <= 1'b0;
      facing_left <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_tick) begin
            state_r <= PLAN;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        PLAN: begin
          dir_r <= dir_s;
          if (dir_s != DIR_NONE) begin
            facing_left <= (dir_s == DIR_LEFT);
            h_cnt_r     <= H_STEPS;
          end else begin
            h_cnt_r     <= 4'd0;
          end
          vy_r    <= vy_plan_s;
          v_cnt_r <= vy_mag(vy_plan_s);
          state_r <= H_CHK;
        end
        H_CHK: begin
          if (h_cnt_r == 4'd0) begin
            state_r <= V_CHK;
          end else if (h_blocked_s) begin
            h_cnt_r <= 4'd0;
            state_r <= V_CHK;
          end else begin
            x_blue   <= (dir_r == DIR_LEFT) ? x_blue - 10'd1 : x_blue + 10'd1;
            h_cnt_r  <= h_cnt_r - 4'd1;
            settle_r <= SETTLE_LAST;
            state_r  <= H_WAIT;
          end
        end
        H_WAIT: begin
          if (settle_r == 4'd0) begin
            state_r  <= H_CHK;
          end else begin
            settle_r <= settle_r - 4'd1;
          end
        end
        V_CHK: begin
          if (v_cnt_r == 5'd0) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (v_blocked_s) begin
            // Only a downward stop means we landed; a ceiling hit leaves on_ground alone.
            if (!vy_r[4]) begin
              on_ground <= 1'b1;
            end else begin
              on_ground <= on_ground;
            end
            vy_r    <= 5'sd0;
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            y_blue    <= vy_r[4] ? y_blue - 9'd1 : y_blue + 9'd1;
            v_cnt_r   <= v_cnt_r - 5'd1;
            on_ground <= 1'b0;
            settle_r  <= SETTLE_LAST;
            state_r   <= V_WAIT;
          end
        end
        V_WAIT: begin
          if (settle_r == 4'd0) begin
            state_r  <= V_CHK;
          end else begin
            settle_r <= settle_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blue_motion.sv
// Directed bench for blue_motion with a one-register-latency contact model
// driven from configurable floor, ceiling and wall positions.
module tb_blue_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_jump = 1'b0;
  logic [3:0] is_collision;
  logic [9:0] x_blue;
  logic [8:0] y_blue;
  logic       on_ground;
  logic       facing_left;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic       floor_en = 1'b1;
  logic [8:0] floor_y  = 9'd422;
  logic       ceil_en  = 1'b0;
  logic [8:0] ceil_y   = 9'd0;
  logic       wall_r_en = 1'b0;
  logic [9:0] wall_r_x  = 10'd0;
  logic       wall_l_en = 1'b0;
  logic [9:0] wall_l_x  = 10'd0;

  always #5 clk = ~clk;

  // Collision stage stand-in: exact-adjacency contact with one register of latency.
  always_ff @(posedge clk) begin
    is_collision <= {wall_l_en && (x_blue == wall_l_x),
                     wall_r_en && (x_blue == wall_r_x),
                     ceil_en && (y_blue == ceil_y),
                     floor_en && (y_blue == floor_y)};
  end

  blue_motion dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_jump     (key_jump),
    .is_collision (is_collision),
    .x_blue       (x_blue),
    .y_blue       (y_blue),
    .on_ground    (on_ground),
    .facing_left  (facing_left),
    .busy         (busy)
  );

  task automatic frame();
    int n;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL burst_timeout busy=%b expected 0 after 200 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (x_blue !== 10'd40 || y_blue !== 9'd390 || busy !== 1'b0 ||
        on_ground !== 1'b0 || facing_left !== 1'b0) begin
      failures++;
      $display("FAIL reset got x=%0d y=%0d busy=%b gnd=%b fl=%b expected 40 390 0 0 0",
               x_blue, y_blue, busy, on_ground, facing_left);
    end
  endtask

  task automatic test_free_fall();
    logic [8:0] exp_y [0:2];
    exp_y[0] = 9'd391;
    exp_y[1] = 9'd393;
    exp_y[2] = 9'd396;
    for (int i = 0; i < 3; i++) begin
      frame();
      checks++;
      if (y_blue !== exp_y[i] || on_ground !== 1'b0) begin
        failures++;
        $display("FAIL free_fall%0d got y=%0d gnd=%b expected y=%0d gnd=0",
                 i, y_blue, on_ground, exp_y[i]);
      end
    end
  endtask

  task automatic test_landing();
    logic [8:0] exp_y [0:3];
    exp_y[0] = 9'd400;
    exp_y[1] = 9'd405;
    exp_y[2] = 9'd411;
    exp_y[3] = 9'd418;
    for (int i = 0; i < 4; i++) begin
      frame();
      checks++;
      if (y_blue !== exp_y[i] || on_ground !== 1'b0) begin
        failures++;
        $display("FAIL fall_accel%0d got y=%0d gnd=%b expected y=%0d gnd=0",
                 i, y_blue, on_ground, exp_y[i]);
      end
    end
    frame();
    checks++;
    if (y_blue !== 9'd422 || on_ground !== 1'b1) begin
      failures++;
      $display("FAIL land got y=%0d gnd=%b expected y=422 gnd=1", y_blue, on_ground);
    end
    frame();
    checks++;
    if (y_blue !== 9'd422 || on_ground !== 1'b1) begin
      failures++;
      $display("FAIL rest got y=%0d gnd=%b expected y=422 gnd=1", y_blue, on_ground);
    end
  endtask

  task automatic test_jump();
    key_jump = 1'b1;
    frame();
    key_jump = 1'b0;
    checks++;
    if (y_blue !== 9'd414 || on_ground !== 1'b0) begin
      failures++;
      $display("FAIL jump got y=%0d gnd=%b expected y=414 gnd=0", y_blue, on_ground);
    end
    ceil_y  = 9'd410;
    ceil_en = 1'b1;
    frame();
    checks++;
    if (y_blue !== 9'd410) begin
      failures++;
      $display("FAIL ceiling got y=%0d expected 410", y_blue);
    end
    ceil_en = 1'b0;
    frame();
    checks++;
    if (y_blue !== 9'd411) begin
      failures++;
      $display("FAIL post_ceiling got y=%0d expected 411", y_blue);
    end
    repeat (4) frame();
    checks++;
    if (y_blue !== 9'd422 || on_ground !== 1'b1) begin
      failures++;
      $display("FAIL reland got y=%0d gnd=%b expected y=422 gnd=1", y_blue, on_ground);
    end
  endtask

  task automatic test_horizontal();
    key_right = 1'b1;
    for (int i = 0; i < 288; i++) frame();
    checks++;
    if (x_blue !== 10'd616 || facing_left !== 1'b0) begin
      failures++;
      $display("FAIL walk_right got x=%0d fl=%b expected x=616 fl=0", x_blue, facing_left);
    end
    frame();
    checks++;
    if (x_blue !== 10'd617) begin
      failures++;
      $display("FAIL to_xmax got x=%0d expected 617", x_blue);
    end
    frame();
    checks++;
    if (x_blue !== 10'd617) begin
      failures++;
      $display("FAIL xmax_clamp got x=%0d expected 617", x_blue);
    end
    key_right = 1'b0;
    key_left  = 1'b1;
    frame();
    checks++;
    if (x_blue !== 10'd615 || facing_left !== 1'b1) begin
      failures++;
      $display("FAIL walk_left got x=%0d fl=%b expected x=615 fl=1", x_blue, facing_left);
    end
    key_right = 1'b1;
    frame();
    checks++;
    if (x_blue !== 10'd615 || facing_left !== 1'b1) begin
      failures++;
      $display("FAIL both_keys got x=%0d fl=%b expected x=615 fl=1", x_blue, facing_left);
    end
    key_right = 1'b0;
    wall_l_x  = 10'd614;
    wall_l_en = 1'b1;
    frame();
    checks++;
    if (x_blue !== 10'd614) begin
      failures++;
      $display("FAIL wall_left got x=%0d expected 614", x_blue);
    end
    wall_l_en = 1'b0;
    key_left  = 1'b0;
    key_right = 1'b1;
    wall_r_x  = 10'd615;
    wall_r_en = 1'b1;
    frame();
    checks++;
    if (x_blue !== 10'd615 || facing_left !== 1'b0) begin
      failures++;
      $display("FAIL wall_right got x=%0d fl=%b expected x=615 fl=0", x_blue, facing_left);
    end
    wall_r_en = 1'b0;
    key_right = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    key_left = 1'b1;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    key_left = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (30) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL extra_tick_busy got busy=%b expected 0", busy);
      end
    end
    checks++;
    if (x_blue !== 10'd613) begin
      failures++;
      $display("FAIL extra_tick_x got x=%0d expected 613", x_blue);
    end
  endtask

  task automatic test_reset_mid_burst();
    key_left = 1'b1;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || x_blue !== 10'd612) begin
      failures++;
      $display("FAIL mid_burst got busy=%b x=%0d expected busy=1 x=612", busy, x_blue);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (x_blue !== 10'd40 || y_blue !== 9'd390 || busy !== 1'b0 ||
        on_ground !== 1'b0 || facing_left !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got x=%0d y=%0d busy=%b gnd=%b fl=%b expected 40 390 0 0 0",
               x_blue, y_blue, busy, on_ground, facing_left);
    end
    key_left = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || x_blue !== 10'd40) begin
      failures++;
      $display("FAIL after_reset got busy=%b x=%0d expected busy=0 x=40", busy, x_blue);
    end
  endtask

  initial begin
    test_reset();
    test_free_fall();
    test_landing();
    test_jump();
    test_horizontal();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blue_motion.md
# blue_motion

Per-frame motion controller for the blue character. It consumes player keys and the 4-bit contact vector from the collision stage, and produces the character's top-left position `x_blue`/`y_blue`, which feeds back into that collision stage. The collision stage reports contact only on exact pixel adjacency and has one register of latency. This block therefore moves the character one pixel at a time and waits for the contact vector to settle after every step.

## Interface
Parameters:
- `X_INIT`, 10'd40: reset x position.
- `Y_INIT`, 9'd390: reset y position.
- `X_MAX`, 10'd617: rightmost legal x (640−23).
- `Y_MAX`, 9'd435: lowest legal y (480−45).
- `H_SPEED`, 2: horizontal pixels attempted per frame.
- `JUMP_V`, 8: initial upward speed, in pixels per frame.
- `V_MAX`, 8: terminal falling speed, in pixels per frame.
- `SETTLE`, 2: wait cycles after each pixel step before contact is trusted. Minimum value is 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle strobe that starts a motion burst.
- `key_left`, `key_right`, `key_jump` in 1 each: level-sensitive keys.
- `is_collision` in 4: contact vector. Bit 0 is floor below, bit 1 is ceiling above, bit 2 is wall right, bit 3 is wall left.
- `x_blue` out 10: registered x position.
- `y_blue` out 9: registered y position.
- `on_ground` out 1: set when the last vertical phase ended on the floor.
- `facing_left` out 1: last horizontal direction pressed.
- `busy` out 1: high while a burst is in progress.

## Operation
- Reset values: `x_blue`=`X_INIT`, `y_blue`=`Y_INIT`, `on_ground`=0, `facing_left`=0, `busy`=0, vy=0, state=IDLE.
- Internal vy is signed 5-bit. Positive means down.
- States: IDLE, PLAN, H_CHK, H_WAIT, V_CHK, V_WAIT.
- IDLE: when `frame_tick` is high, go to PLAN.
- PLAN (one cycle). It latches the following, then goes to H_CHK.
  - Horizontal direction: right if only `key_right` is high; left if only `key_left` is high; none if both or neither are high.
  - `facing_left` updates only when a direction exists.
  - Step count h_cnt=`H_SPEED` when a direction exists, else 0.
  - Velocity update:
    - If `is_collision[0]` and `key_jump`: vy=−`JUMP_V`.
    - Else if `is_collision[0]`: vy=0.
    - Else: vy=min(vy+1, `V_MAX`).
  - v_cnt=|vy|.
- H_CHK:
  - If h_cnt=0, go to V_CHK.
  - If blocked, clear h_cnt and go to V_CHK. Blocked means:
    - moving right: `is_collision[2]` or `x_blue`=`X_MAX`;
    - moving left: `is_collision[3]` or `x_blue`=0.
  - Otherwise `x_blue`±1, h_cnt−1, go to H_WAIT.
- H_WAIT: stay `SETTLE` cycles, then return to H_CHK.
- V_CHK:
  - If v_cnt=0, go to IDLE.
  - Moving down, blocked when `is_collision[0]` or `y_blue`=`Y_MAX`. Then vy=0, `on_ground`=1, go to IDLE.
  - Moving up, blocked when `is_collision[1]` or `y_blue`=0. Then vy=0, go to IDLE.
  - Otherwise `y_blue`±1, v_cnt−1, `on_ground`=0, go to V_WAIT.
- V_WAIT: stay `SETTLE` cycles, then return to V_CHK.
- If v_cnt reaches 0 while moving down and unblocked, `on_ground` stays 0. It is re-evaluated at the next PLAN.
- All position arithmetic is unsigned at full port width. The bounds checks prevent wrap, so x never exceeds `X_MAX` and y never underflows.

## Timing
- `busy`=1 in every state except IDLE.
- Burst latency is 2 + (steps taken)·(`SETTLE`+1) + (checks) cycles. With defaults the worst case is under 40 cycles, far below a frame period.
- `frame_tick` while `busy`=1 is ignored: no queueing, no error.
- A position changes on exactly one clock edge per step. The contact vector is first consumed at least `SETTLE`+1 edges after that change.
- Keys are sampled only in PLAN. Changes mid-burst have no effect until the next frame.
- Asserting `rst` mid-burst returns all outputs to their reset values immediately. The burst is abandoned.

## Structure
- Shared package `jf_pkg` holds:
  - the `motion_state_t` enum;
  - `BLUE_W`=23, `BLUE_H`=45, `SCREEN_W`=640, `SCREEN_H`=480;
  - the contact-bit index constants `COL_DOWN`=0, `COL_UP`=1, `COL_RIGHT`=2, `COL_LEFT`=3.
- No sub-module. The settle counter and step counters are inline.

## Test plan
- Reset held, then released → `x_blue`=40, `y_blue`=390, `busy`=0, `on_ground`=0.
- Free fall from y=390 with `is_collision`=0, 3 ticks → vy runs 1,2,3 and y=396. Each burst returns to IDLE with `busy`=0.
- Floor model returns bit 0 when y=400, falling at vy=8 → y stops at 400, vy=0, `on_ground`=1. No step is taken past contact.
- On ground with `key_jump` held for one tick → y decreases by 8 and `on_ground`=0. With ceiling bit 1 forced at y=395, y stops at 395 and vy=0.
- `key_right` with x=616 → x=617 after one tick. The next tick leaves x=617 because of the `X_MAX` clamp. Wall bit 2 asserted stops motion the same way.
- Second `frame_tick` during a burst, and `rst` pulsed mid-burst → the extra tick has no effect; reset returns outputs to reset values on the asserting edge.
